// File: rtl/vfb_pkg.sv
// rtl/vfb_pkg.sv - shared types and helpers for the multi-frame video buffer
package vfb_pkg;

    typedef enum logic {
        VFB_IDLE  = 1'b0,
        VFB_CLEAR = 1'b1
    } vfb_state_e;

    localparam int MAX_PIX_W = 64;
    localparam int MAX_CH_W  = 16;

    // Caller truncates the result to its own channel width.
    function automatic logic [MAX_CH_W-1:0] get_ch(input logic [MAX_PIX_W-1:0] pix,
                                                   input int unsigned c,
                                                   input int unsigned ch_w);
        return MAX_CH_W'(pix >> (c * ch_w));
    endfunction

endpackage

// File: rtl/vfb_ch_bank.sv
// rtl/vfb_ch_bank.sv - one channel plane: simple dual-port RAM with registered read
module vfb_ch_bank #(
    parameter int DW    = 4,
    parameter int AW    = 17,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array itself holds stale pixels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_frame_buf.sv
// rtl/video_frame_buf.sv - multi-frame video memory with vsync swap and clear engine; option VFB_TEAR_CHECK_EN
module video_frame_buf
    import vfb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int NUM_FRAMES = 2,
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [NUM_CH*CH_W-1:0]         wr_data_i,
    input  logic [NUM_CH-1:0]              wr_ch_en_i,
    input  logic                           rd_en_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    output logic [NUM_CH*CH_W-1:0]         rd_data_o,
    output logic                           rd_valid_o,
    input  logic                           clr_req_i,
    input  logic [NUM_CH*CH_W-1:0]         clr_color_i,
    input  logic                           swap_req_i,
    input  logic                           vsync_i,
    output logic                           swap_pending_o,
    output logic                           swap_done_o,
    output logic                           busy_o,
`ifdef VFB_TEAR_CHECK_EN
    output logic                           tear_err_o,
`endif
    output logic [$clog2(NUM_FRAMES)-1:0]  front_idx_o
);

    localparam int FRAME_W = $clog2(NUM_FRAMES);
    localparam int PIX_W   = NUM_CH * CH_W;
    localparam int PA_W    = ADDR_W + FRAME_W;
    localparam int DEPTH   = NUM_FRAMES << ADDR_W;

    vfb_state_e         state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [PIX_W-1:0]   clr_color_q;
    logic [FRAME_W-1:0] front_q, back_q, back_d;
    logic               swap_pending_q, swap_pending_d;
    logic               swap_done_q;
    logic               rd_valid_q;

    logic               idle, clr_active, wr_fire, commit;
    logic [PA_W-1:0]    waddr;
    logic [PIX_W-1:0]   src_pix;

    assign idle       = (state_q == VFB_IDLE);
    assign clr_active = (state_q == VFB_CLEAR);
    // A clear request steals the write port in the same cycle it arrives.
    assign wr_ready_o = idle && !clr_req_i;
    assign wr_fire    = wr_valid_i && wr_ready_o;

    assign swap_pending_d = swap_pending_q || swap_req_i;
    assign commit         = vsync_i && swap_pending_d && idle;
    assign back_d         = (back_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : back_q + 1'b1;

    assign waddr   = clr_active ? {back_q, cnt_q} : {back_q, wr_addr_i};
    assign src_pix = clr_active ? clr_color_q : wr_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= VFB_IDLE;
            cnt_q          <= '0;
            clr_color_q    <= '0;
            front_q        <= '0;
            back_q         <= FRAME_W'(1);
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            case (state_q)
                VFB_IDLE: begin
                    if (clr_req_i) begin
                        state_q     <= VFB_CLEAR;
                        cnt_q       <= '0;
                        clr_color_q <= clr_color_i;
                    end
                end
                VFB_CLEAR: begin
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= VFB_IDLE;
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= VFB_IDLE;
            endcase

            if (commit) begin
                front_q        <= back_q;
                back_q         <= back_d;
                swap_pending_q <= 1'b0;
            end else begin
                swap_pending_q <= swap_pending_d;
            end
            swap_done_q <= commit;
            rd_valid_q  <= rd_en_i;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CH_W-1:0] wdata;
        assign wdata = CH_W'(get_ch(MAX_PIX_W'(src_pix), c, CH_W));

        vfb_ch_bank #(
            .DW   (CH_W),
            .AW   (PA_W),
            .DEPTH(DEPTH)
        ) u_bank (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .we_i   (clr_active || (wr_fire && wr_ch_en_i[c])),
            .waddr_i(waddr),
            .wdata_i(wdata),
            .re_i   (rd_en_i),
            .raddr_i({front_q, rd_addr_i}),
            .rdata_o(rd_data_o[c*CH_W +: CH_W])
        );
    end

`ifdef VFB_TEAR_CHECK_EN
    logic tear_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tear_q <= 1'b0;
        end else if ((wr_fire && swap_pending_q && vsync_i) || (swap_req_i && clr_active)) begin
            tear_q <= 1'b1;
        end
    end
    assign tear_err_o = tear_q;
`endif

    assign rd_valid_o     = rd_valid_q;
    assign swap_pending_o = swap_pending_q;
    assign swap_done_o    = swap_done_q;
    assign busy_o         = clr_active;
    assign front_idx_o    = front_q;

endmodule

// File: tb/tb_video_frame_buf.sv
// tb/tb_video_frame_buf.sv - directed bench for video_frame_buf (ADDR_W=4, NUM_FRAMES=3)
module tb_video_frame_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [2:0]  wr_ch_en;
    logic        rd_en, rd_valid;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        swap_req, vsync, swap_pending, swap_done, busy;
    logic [1:0]  front_idx;
`ifdef VFB_TEAR_CHECK_EN
    logic        tear_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    video_frame_buf #(
        .ADDR_W(4), .NUM_FRAMES(3), .NUM_CH(3), .CH_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_ch_en_i(wr_ch_en),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .clr_req_i(clr_req), .clr_color_i(clr_color),
        .swap_req_i(swap_req), .vsync_i(vsync),
        .swap_pending_o(swap_pending), .swap_done_o(swap_done), .busy_o(busy),
`ifdef VFB_TEAR_CHECK_EN
        .tear_err_o(tear_err),
`endif
        .front_idx_o(front_idx)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
        logic [2:0]  en;
    } wvec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] exp;
    } rvec_t;

    wvec_t wv[9];
    rvec_t rv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [11:0] d, input logic [2:0] en);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_ch_en = en;
        #1;
        check("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [3:0] a, input logic [11:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_swap(input logic [1:0] exp_front);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap_pending_set", 32'(swap_pending), 32'd1);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("front_idx", 32'(front_idx), 32'(exp_front));
        check("swap_done_pulse", 32'(swap_done), 32'd1);
        check("swap_pending_clr", 32'(swap_pending), 32'd0);
        tick();
        check("swap_done_once", 32'(swap_done), 32'd0);
    endtask

    initial begin
        int n, nb;

        wv[0] = '{4'h5, 12'hABC, 3'b111};
        wv[1] = '{4'h5, 12'h123, 3'b010};
        wv[2] = '{4'h3, 12'h456, 3'b111};
        wv[3] = '{4'h3, 12'h0F9, 3'b101};
        wv[4] = '{4'h7, 12'h321, 3'b001};
        wv[5] = '{4'h7, 12'h654, 3'b110};
        wv[6] = '{4'hA, 12'hABC, 3'b111};
        wv[7] = '{4'hF, 12'hFFF, 3'b111};
        wv[8] = '{4'h0, 12'h000, 3'b111};
        rv[0] = '{4'h5, 12'hA2C};
        rv[1] = '{4'h3, 12'h059};
        rv[2] = '{4'h7, 12'h651};
        rv[3] = '{4'hA, 12'hABC};
        rv[4] = '{4'hF, 12'hFFF};
        rv[5] = '{4'h0, 12'h000};

        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_ch_en = 0;
        rd_en = 0; rd_addr = 0; clr_req = 0; clr_color = 0; swap_req = 0; vsync = 0;
        tick(); tick();
        check("rst_front_idx", 32'(front_idx), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef VFB_TEAR_CHECK_EN
        check("rst_tear_err", 32'(tear_err), 32'd0);
`endif
        rst = 1'b0;

        // Fill frame 1 (back), swap it to the front, read back with masks applied.
        for (int i = 0; i < 9; i++) do_write(wv[i].addr, wv[i].data, wv[i].en);
        do_swap(2'd1);
        for (int i = 0; i < 6; i++) do_read("rd_table", rv[i].addr, rv[i].exp);
        tick();
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'h000);

        // Clear of frame 2 with a colliding host write; swap requested mid-clear.
        clr_req = 1'b1; clr_color = 12'hF00;
        wr_valid = 1'b1; wr_addr = 4'h2; wr_data = 12'h777; wr_ch_en = 3'b111;
        #1;
        check("clr_blocks_write", 32'(wr_ready), 32'd0);
        tick();
        clr_req = 1'b0; wr_valid = 1'b0;
        n = 0; nb = 0;
        while (busy && n < 40) begin
            if (!wr_ready) nb++;
            swap_req = (n == 4);
            vsync    = (n == 8);
            tick();
            n++;
        end
        swap_req = 1'b0; vsync = 1'b0;
        check("clear_busy_cycles", 32'(n), 32'd16);
        check("clear_ready_low_cycles", 32'(nb), 32'd16);
        check("pending_through_clear", 32'(swap_pending), 32'd1);
        check("no_commit_in_clear", 32'(front_idx), 32'd1);
`ifdef VFB_TEAR_CHECK_EN
        check("tear_swap_while_busy", 32'(tear_err), 32'd1);
`endif
        for (int i = 0; i < 6; i++) do_read("front_untouched", rv[i].addr, rv[i].exp);

        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("deferred_commit_front", 32'(front_idx), 32'd2);
        check("deferred_commit_done", 32'(swap_done), 32'd1);
        for (int a = 0; a < 16; a++) do_read("clear_fill", 4'(a), 12'hF00);

        // Writes to back frame 0 while the display keeps reading the same address.
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_addr = 4'h9; wr_data = 12'h111 * 12'(k + 1); wr_ch_en = 3'b111;
            rd_en = 1'b1; rd_addr = 4'h9;
            tick();
            check("display_stable", 32'(rd_data), 32'hF00);
        end
        // swap_req, vsync and a write all in one cycle: commit now, write hits old back.
        wr_data = 12'h5A5; swap_req = 1'b1; vsync = 1'b1;
        tick();
        wr_valid = 1'b0; rd_en = 1'b0; swap_req = 1'b0; vsync = 1'b0;
        check("commit_cycle_read_old_front", 32'(rd_data), 32'hF00);
        check("same_cycle_commit_front", 32'(front_idx), 32'd0);
        check("same_cycle_commit_done", 32'(swap_done), 32'd1);
        do_read("commit_cycle_write", 4'h9, 12'h5A5);

        // Reset in the middle of a clear.
        clr_req = 1'b1; clr_color = 12'h0F0;
        tick();
        clr_req = 1'b0;
        tick(); tick();
        check("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midclr_rst_busy", 32'(busy), 32'd0);
        check("midclr_rst_wr_ready", 32'(wr_ready), 32'd1);
        check("midclr_rst_front", 32'(front_idx), 32'd0);
        check("midclr_rst_pending", 32'(swap_pending), 32'd0);
`ifdef VFB_TEAR_CHECK_EN
        check("midclr_rst_tear", 32'(tear_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
